// File: rtl/imem_loader.sv
// Byte-stream boot loader: fills instruction memory, then releases the core.
// Define LOADER_CHKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int ADDR_W      = 12,
    parameter int DEPTH_WORDS = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_CNT_LO = 3'd0;
    localparam logic [2:0] S_CNT_HI = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef LOADER_CHKSUM_EN
    localparam logic [2:0] S_CHK    = 3'd3;
    localparam logic [2:0] S_FINISH = S_CHK;
`else
    localparam logic [2:0] S_FINISH = 3'd4;
`endif
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

    logic [2:0]        state;
    logic [7:0]        cnt_lo;
    logic [15:0]       words_left;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       wbuf;
    logic [15:0]       count_n;
    logic              too_big;
    logic              accept;
`ifdef LOADER_CHKSUM_EN
    logic [7:0]        chk;
`endif

    assign count_n = {in_data, cnt_lo};
    assign too_big = {1'b0, count_n} > DEPTH_LIM;

    always_comb begin
        in_ready = reset && !start
                && (state != S_DONE) && (state != S_ERR);
    end

    assign accept = in_valid && in_ready;

    // Status flags are registered one cycle behind the state so that
    // done rises strictly after the final write strobe.
    always_ff @(posedge clk) begin
        wr_en <= 1'b0;
        if (!reset) begin
            state      <= S_CNT_LO;
            cnt_lo     <= '0;
            words_left <= '0;
            idx        <= '0;
            byte_cnt   <= '0;
            wbuf       <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef LOADER_CHKSUM_EN
            chk        <= '0;
`endif
        end else if (start) begin
            state     <= S_CNT_LO;
            idx       <= '0;
            byte_cnt  <= '0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef LOADER_CHKSUM_EN
            chk       <= '0;
`endif
        end else begin
            core_hold <= (state != S_DONE);
            done      <= (state == S_DONE);
            err       <= (state == S_ERR);
            if (accept) begin
`ifdef LOADER_CHKSUM_EN
                chk <= chk ^ in_data;
`endif
                unique case (state)
                    S_CNT_LO: begin
                        cnt_lo <= in_data;
                        state  <= S_CNT_HI;
                    end
                    S_CNT_HI: begin
                        if (count_n == 16'd0) begin
                            state <= S_FINISH;
                        end else if (too_big) begin
                            state <= S_ERR;
                        end else begin
                            words_left <= count_n;
                            state      <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        unique case (byte_cnt)
                            2'd0: wbuf[7:0]   <= in_data;
                            2'd1: wbuf[15:8]  <= in_data;
                            2'd2: wbuf[23:16] <= in_data;
                            default: begin
                                wr_en      <= 1'b1;
                                wr_addr    <= idx;
                                wr_data    <= {in_data, wbuf};
                                idx        <= idx + ADDR_W'(1);
                                words_left <= words_left - 16'd1;
                                if (words_left == 16'd1)
                                    state <= S_FINISH;
                            end
                        endcase
                    end
`ifdef LOADER_CHKSUM_EN
                    S_CHK: begin
                        state <= (in_data == chk) ? S_DONE : S_ERR;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with an image-level scoreboard model.
module tb_imem_loader;

    localparam int AW = 12;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          core_hold;
    logic          done;
    logic          err;

    int  total = 0;
    int  bad   = 0;
    int  n_wr  = 0;
    wr_t exp_q[$];

    imem_loader #(.ADDR_W(AW), .DEPTH_WORDS(4096)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_hold(core_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next modelled word.
    always @(negedge clk) begin
        if (reset && done && err)
            check("done_err_both", 32'd1, 32'd0);
        if (wr_en === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {20'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {20'd0, wr_addr}, {20'd0, e.a});
                check("wr_data", wr_data, e.d);
            end
        end
    end

    function automatic logic [7:0] xor_of(input logic [7:0] b[$]);
        logic [7:0] x = 8'h00;
        foreach (b[i]) x ^= b[i];
        return x;
    endfunction

    // Image-level model: returns expected outcome (1 = error) and word count.
    task automatic model(input logic [7:0] b[$], output bit exp_err,
                         output int nw);
        int n;
        n = int'(b[0]) + 256 * int'(b[1]);
        exp_err = 1'b0;
        nw = 0;
        if (n > 4096) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            wr_t e;
            e.a = AW'(w);
            e.d = {b[2+4*w+3], b[2+4*w+2], b[2+4*w+1], b[2+4*w]};
            exp_q.push_back(e);
            nw++;
        end
`ifdef LOADER_CHKSUM_EN
        begin
            logic [7:0] x = 8'h00;
            for (int i = 0; i < 2 + 4 * n; i++) x ^= b[i];
            exp_err = (b[2+4*n] != x);
        end
`endif
    endtask

    task automatic send(input logic [7:0] b[$], input int gap);
        foreach (b[i]) begin
            int tries = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b[i];
            while (!in_ready && tries < 50) begin
                @(negedge clk);
                tries++;
            end
            if (tries == 50)
                check("ready_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_end();
        int t = 0;
        @(negedge clk);
        while (!(done || err) && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_image(input string tag, input logic [7:0] b[$],
                             input int gap);
        bit ee;
        int nw;
        int w0;
        w0 = n_wr;
        model(b, ee, nw);
        send(b, gap);
        wait_end();
        check({tag, "_err"}, {31'd0, err}, {31'd0, ee});
        check({tag, "_done"}, {31'd0, done}, {31'd0, !ee});
        check({tag, "_hold"}, {31'd0, core_hold}, {31'd0, ee});
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_nwr"}, n_wr - w0, nw);
        check({tag, "_qempty"}, exp_q.size(), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        #1 check("start_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_hold", {31'd0, core_hold}, 32'd1);
        check("start_done", {31'd0, done}, 32'd0);
        check("start_err", {31'd0, err}, 32'd0);
        check("start_ready", {31'd0, in_ready}, 32'd1);
    endtask

    logic [7:0] img[$];
    logic [7:0] base[$];

    initial begin
        bit ee;
        int nw;
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_addr", {20'd0, wr_addr}, 32'd0);
        check("rst_data", wr_data, 32'd0);
        check("rst_hold", {31'd0, core_hold}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        base = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00};

        // Pin the model against hand-derived values.
        check("lit_xor", {24'd0, xor_of(base)}, 32'h0000_0092);
        model(base, ee, nw);
        check("lit_nw", nw, 32'd2);
        check("lit_w0", exp_q[0].d, 32'h0000_0013);
        check("lit_w1", exp_q[1].d, 32'h0010_0093);
        check("lit_a1", {20'd0, exp_q[1].a}, 32'd1);
        exp_q.delete();

        img = base;
`ifdef LOADER_CHKSUM_EN
        img.push_back(xor_of(base));
`endif
        run_image("img", img, 0);

        pulse_start();
        run_image("gap", img, 1);

        pulse_start();
        img = '{8'h00, 8'h00};
`ifdef LOADER_CHKSUM_EN
        img.push_back(8'h00);
`endif
        run_image("zero", img, 0);

        pulse_start();
        img = '{8'h01, 8'h10};
        run_image("big", img, 0);

        // N equal to the depth limit is accepted.
        pulse_start();
        img = '{8'h00, 8'h10};
        send(img, 0);
        repeat (3) @(negedge clk);
        check("max_err", {31'd0, err}, 32'd0);
        check("max_ready", {31'd0, in_ready}, 32'd1);

        pulse_start();
        img = '{8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                8'h01, 8'h02, 8'h03, 8'h04, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CHKSUM_EN
        img.push_back(xor_of(img));
`endif
        run_image("three", img, 2);

        // Reset mid-word must discard the partial word.
        pulse_start();
        img = '{8'h02, 8'h00, 8'h13, 8'h00};
        send(img, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_hold", {31'd0, core_hold}, 32'd1);
        img = base;
`ifdef LOADER_CHKSUM_EN
        img.push_back(xor_of(base));
`endif
        run_image("restream", img, 0);

`ifdef LOADER_CHKSUM_EN
        pulse_start();
        img = base;
        img.push_back(8'h83);
        run_image("badchk", img, 0);
        pulse_start();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
